// File: rtl/sr_wr_arb.sv
// Special-register file write-port arbiter: round-robin grant with burst locking,
// a lock watchdog and flush abort, feeding a registered single-cycle write port.
module sr_wr_arb #(
   parameter int NREQ     = 3,
   parameter int IDXW     = 4,
   parameter int DW       = 48,
   parameter int LOCK_MAX = 15
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic [NREQ-1:0]      iw_req,
   input  logic [NREQ-1:0]      iw_last,
   input  logic [NREQ*IDXW-1:0] iw_idx,
   input  logic [NREQ*DW-1:0]   iw_data,
   input  logic                 iw_flush,
   output logic [NREQ-1:0]      ow_gnt,
   output logic                 ow_sr_we,
   output logic [IDXW-1:0]      ow_sr_idx,
   output logic [DW-1:0]        ow_sr_data,
   output logic                 ow_busy,
   output logic [2:0]           ow_owner,
   output logic                 ow_lock_abort
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state;
   logic [2:0]      ptr;
   logic [2:0]      owner;
   logic [7:0]      wd;

   logic [7:0]      req_ext;
   logic [2:0]      scan;
   logic [2:0]      sel;
   logic            found;
   logic            acc;
   logic            sel_last;
   logic [IDXW-1:0] sel_idx;
   logic [DW-1:0]   sel_data;
   logic [NREQ-1:0] gnt;

   function automatic logic [2:0] nxt(input logic [2:0] x);
      return (x == 3'(NREQ-1)) ? 3'd0 : x + 3'd1;
   endfunction

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      req_ext  = 8'(iw_req);
      scan     = '0;
      sel      = owner;
      found    = 1'b0;
      gnt      = '0;
      sel_last = 1'b0;
      sel_idx  = '0;
      sel_data = '0;
      if (state == LOCK) begin
         found = 1'b1;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            scan = 3'((int'(ptr) + k) % NREQ);
            if (!found && req_ext[scan]) begin
               found = 1'b1;
               sel   = scan;
            end
         end
      end
      // Grant is forced low by flush and while reset is asserted.
      for (int i = 0; i < NREQ; i++) begin
         if (sel == 3'(i)) begin
            gnt[i]   = found & ~iw_flush & iw_rst_n;
            sel_last = iw_last[i];
            sel_idx  = iw_idx[i*IDXW +: IDXW];
            sel_data = iw_data[i*DW +: DW];
         end
      end
      acc = |(gnt & iw_req);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         wd            <= '0;
         ow_sr_we      <= 1'b0;
         ow_sr_idx     <= '0;
         ow_sr_data    <= '0;
         ow_lock_abort <= 1'b0;
      end else begin
         ow_sr_we      <= acc;
         ow_lock_abort <= 1'b0;
         if (acc) begin
            ow_sr_idx  <= sel_idx;
            ow_sr_data <= sel_data;
            owner      <= sel;
         end
         case (state)
            IDLE: begin
               if (acc) begin
                  if (sel_last) begin
                     ptr <= nxt(sel);
                  end else begin
                     state <= LOCK;
                     wd    <= '0;
                  end
               end
            end
            LOCK: begin
               if (iw_flush) begin
                  state         <= IDLE;
                  ow_lock_abort <= 1'b1;
               end else if (acc) begin
                  wd <= '0;
                  if (sel_last) begin
                     state <= IDLE;
                     ptr   <= nxt(owner);
                  end
               end else if (wd == 8'(LOCK_MAX-1)) begin
                  // Owner idled too long inside its burst: release and move past it.
                  state         <= IDLE;
                  ptr           <= nxt(owner);
                  wd            <= '0;
                  ow_lock_abort <= 1'b1;
               end else begin
                  wd <= wd + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ow_gnt   = gnt;
   assign ow_busy  = (state == LOCK);
   assign ow_owner = owner;

endmodule

// File: tb/tb_sr_wr_arb.sv
// Self-checking bench for sr_wr_arb: vector table plus hand-written burst, watchdog,
// flush and reset sequences; expected writes go through a scoreboard queue.
module tb_sr_wr_arb;
   localparam int NREQ     = 3;
   localparam int IDXW     = 4;
   localparam int DW       = 48;
   localparam int LOCK_MAX = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      last;
   logic [NREQ*IDXW-1:0] idx;
   logic [NREQ*DW-1:0]   data;
   logic                 flush;
   logic [NREQ-1:0]      ow_gnt;
   logic                 ow_sr_we;
   logic [IDXW-1:0]      ow_sr_idx;
   logic [DW-1:0]        ow_sr_data;
   logic                 ow_busy;
   logic [2:0]           ow_owner;
   logic                 ow_lock_abort;

   always #5 clk = ~clk;

   sr_wr_arb #(.NREQ(NREQ), .IDXW(IDXW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .iw_clk(clk), .iw_rst_n(rst_n), .iw_req(req), .iw_last(last), .iw_idx(idx),
      .iw_data(data), .iw_flush(flush), .ow_gnt(ow_gnt), .ow_sr_we(ow_sr_we),
      .ow_sr_idx(ow_sr_idx), .ow_sr_data(ow_sr_data), .ow_busy(ow_busy),
      .ow_owner(ow_owner), .ow_lock_abort(ow_lock_abort)
   );

   typedef struct {
      logic [2:0] req;
      logic [2:0] last;
      logic       flush;
      logic [2:0] gnt;    // expected combinational grant this cycle
      logic       busy;   // expected ow_busy during this cycle
      logic       abort;  // expected ow_lock_abort during this cycle
   } vec_t;

   typedef struct {
      logic [IDXW-1:0] idx;
      logic [DW-1:0]   data;
      logic [2:0]      owner;
   } wr_t;

   wr_t  sb[$];
   wr_t  last_wr;
   logic exp_we;
   int   cmp_n;
   int   fail_n;
   int   cyc_n;
   vec_t tbl[10];

   function automatic vec_t v(input logic [2:0] r, input logic [2:0] l, input logic f,
                              input logic [2:0] g, input logic b, input logic a);
      vec_t t;
      t.req = r; t.last = l; t.flush = f; t.gnt = g; t.busy = b; t.abort = a;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         fail_n++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outputs registered at the previous edge, sampled at the falling edge.
   task automatic check_outputs(input string tag, input logic busy, input logic abort);
      check($sformatf("%s busy", tag), 64'(ow_busy), 64'(busy));
      check($sformatf("%s abort", tag), 64'(ow_lock_abort), 64'(abort));
      check($sformatf("%s we", tag), 64'(ow_sr_we), 64'(exp_we));
      if (exp_we && sb.size() > 0) last_wr = sb.pop_front();
      check($sformatf("%s sr_idx", tag), 64'(ow_sr_idx), 64'(last_wr.idx));
      check($sformatf("%s sr_data", tag), 64'(ow_sr_data), 64'(last_wr.data));
      check($sformatf("%s owner", tag), 64'(ow_owner), 64'(last_wr.owner));
   endtask

   task automatic apply(input vec_t t, input string tag, input bit ovr = 1'b0,
                        input logic [IDXW-1:0] oidx = '0, input logic [DW-1:0] odata = '0);
      wr_t e;
      @(negedge clk);
      check_outputs(tag, t.busy, t.abort);
      cyc_n++;
      req   = t.req;
      last  = t.last;
      flush = t.flush;
      for (int i = 0; i < NREQ; i++) begin
         idx[i*IDXW +: IDXW] = IDXW'(cyc_n * 3 + i);
         data[i*DW +: DW]    = DW'((longint'(cyc_n) << 8) + longint'(i));
      end
      if (ovr) begin
         idx[IDXW +: IDXW] = oidx;
         data[DW +: DW]    = odata;
      end
      #1;
      check($sformatf("%s gnt", tag), 64'(ow_gnt), 64'(t.gnt));
      exp_we = |(t.req & t.gnt);
      for (int i = 0; i < NREQ; i++) begin
         if (t.req[i] && t.gnt[i]) begin
            e.idx   = idx[i*IDXW +: IDXW];
            e.data  = data[i*DW +: DW];
            e.owner = 3'(i);
            sb.push_back(e);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check($sformatf("%s gnt", tag), 64'(ow_gnt), 64'd0);
      check($sformatf("%s we", tag), 64'(ow_sr_we), 64'd0);
      check($sformatf("%s sr_idx", tag), 64'(ow_sr_idx), 64'd0);
      check($sformatf("%s sr_data", tag), 64'(ow_sr_data), 64'd0);
      check($sformatf("%s owner", tag), 64'(ow_owner), 64'd0);
      check($sformatf("%s busy", tag), 64'(ow_busy), 64'd0);
      check($sformatf("%s abort", tag), 64'(ow_lock_abort), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cmp_n   = 0;
      fail_n  = 0;
      cyc_n   = 0;
      exp_we  = 1'b0;
      last_wr = '{idx: '0, data: '0, owner: '0};
      rst_n   = 1'b0;
      req     = 3'b111;
      last    = 3'b111;
      flush   = 1'b0;
      idx     = '0;
      data    = '0;

      // Requests are high during reset, yet nothing may be granted.
      #12;
      check_all_zero("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      req = '0;

      // Single beats, rotation, flush in IDLE.
      tbl[0] = v(3'b111, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0);
      tbl[1] = v(3'b111, 3'b111, 1'b0, 3'b010, 1'b0, 1'b0);
      tbl[2] = v(3'b111, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0);
      tbl[3] = v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
      tbl[4] = v(3'b110, 3'b111, 1'b0, 3'b010, 1'b0, 1'b0);
      tbl[5] = v(3'b011, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0);
      tbl[6] = v(3'b101, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0);
      tbl[7] = v(3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[8] = v(3'b001, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[9] = v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // Atomic burst from requester 1 (PC then FL) while requester 0 waits.
      apply(v(3'b001, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0), "burst_pre");
      apply(v(3'b011, 3'b001, 1'b0, 3'b010, 1'b0, 1'b0), "burst_pc", 1'b1, 4'h0, 48'h0000_0100);
      apply(v(3'b011, 3'b011, 1'b0, 3'b010, 1'b1, 1'b0), "burst_fl", 1'b1, 4'h1, 48'h1);
      apply(v(3'b011, 3'b011, 1'b0, 3'b001, 1'b0, 1'b0), "burst_post");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0), "burst_idle");

      // Watchdog: requester 2 opens a burst and goes silent.
      apply(v(3'b100, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0), "wd_open");
      apply(v(3'b001, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0), "wd_idle1");
      apply(v(3'b001, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0), "wd_idle2");
      apply(v(3'b001, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0), "wd_idle3");
      apply(v(3'b001, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1), "wd_release");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0), "wd_after");

      // Flush beats the owner's last beat; pointer stays where it was.
      apply(v(3'b010, 3'b111, 1'b0, 3'b010, 1'b0, 1'b0), "fl_pre");
      apply(v(3'b001, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0), "fl_open");
      apply(v(3'b001, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0), "fl_flush");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1), "fl_pulse");
      apply(v(3'b011, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0), "fl_ptr");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0), "fl_idle");

      // Owner beats inside a burst restart the watchdog.
      apply(v(3'b010, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0), "wdr_open");
      apply(v(3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_gap1");
      apply(v(3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_gap2");
      apply(v(3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_beat");
      apply(v(3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_gap3");
      apply(v(3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_gap4");
      apply(v(3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0), "wdr_close");
      apply(v(3'b011, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0), "wdr_ptr");

      // Asynchronous reset in the middle of a locked burst.
      apply(v(3'b010, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0), "rst_open");
      apply(v(3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0), "rst_lock");
      req = 3'b010;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      last_wr = '{idx: '0, data: '0, owner: '0};
      exp_we  = 1'b0;
      sb.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      req  = '0;
      last = '0;
      apply(v(3'b011, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0), "rst_after");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0), "rst_idle");
      apply(v(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0), "end");

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule

// File: doc/sr_wr_arb.md
Name: sr_wr_arb

Overview:
- Arbitrates the single special-register (SR) file write port among NREQ requesters, e.g. EX-stage SR write-back, trap/interrupt sequencer and debug unit.
- Round-robin grant with burst locking, so multi-write sequences (trap saving PC then FL) are atomic.
- Registered write port feeds the SR file.
- Lock watchdog and flush input keep a stalled requester from wedging the port.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDXW, 4, SR index width.
- DW, 48, SR data width (matches address width).
- LOCK_MAX, 15, idle cycles allowed inside a locked burst before forced release (1..255).

Ports:
- iw_clk  in  1  clock, all state on rising edge.
- iw_rst_n  in  1  asynchronous active-low reset.
- iw_req  in  NREQ  per-requester write request (valid).
- iw_last  in  NREQ  per-requester: this beat ends the burst.
- iw_idx  in  NREQ*IDXW  packed SR index, requester i at [i*IDXW +: IDXW].
- iw_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW].
- iw_flush  in  1  pipeline flush: abort any lock, no grant this cycle.
- ow_gnt  out  NREQ  one-hot ready; beat i accepted when iw_req[i] & ow_gnt[i].
- ow_sr_we  out  1  SR file write enable.
- ow_sr_idx  out  IDXW  SR file write index.
- ow_sr_data  out  DW  SR file write data.
- ow_busy  out  1  high while in LOCK state.
- ow_owner  out  3  index of last accepted requester / lock owner.
- ow_lock_abort  out  1  one-cycle pulse when a lock is released by watchdog or flush.

Behaviour:
- Reset (async, iw_rst_n=0):
  - State IDLE, rr pointer 0, watchdog 0.
  - ow_sr_we=0, ow_sr_idx=0, ow_sr_data=0, ow_owner=0, ow_lock_abort=0.
  - ow_gnt=0 while in reset.
- Reset mid-burst drops the lock silently: no abort pulse, no write.
- ow_gnt is combinational from state, pointer, iw_req and iw_flush. It is at most one-hot and is 0 when iw_flush=1.
- IDLE:
  - Winner = first i with iw_req[i], scanning ptr, ptr+1, ..., wrapping mod NREQ. ow_gnt[winner]=1.
  - Accepted with iw_last=1: stay IDLE, ptr <= (winner+1) mod NREQ.
  - Accepted with iw_last=0: go to LOCK, owner <= winner, watchdog <= 0.
  - No requests: ptr unchanged.
- LOCK:
  - ow_gnt = onehot(owner) only; all other requests wait.
  - Owner beat accepted: watchdog <= 0. If iw_last=1, go to IDLE and ptr <= (owner+1) mod NREQ.
  - Owner iw_req=0: watchdog++. When watchdog reaches LOCK_MAX: go to IDLE, ptr <= owner+1, pulse ow_lock_abort next cycle.
  - iw_flush=1: go to IDLE, ptr unchanged, pulse ow_lock_abort next cycle. Flush in IDLE has no state effect and no pulse.
- Write port latency 1:
  - On the cycle after an accepted beat: ow_sr_we=1 with that beat's idx/data; ow_owner updated.
  - Otherwise ow_sr_we=0; ow_sr_idx and ow_sr_data hold their last values.
  - Back-to-back accepted beats give back-to-back writes, one per cycle, with no bubble.
- Requester rule: idx, data and last must stay stable while req=1 and gnt=0. Dropping req before grant is legal (no write).
- Flush and owner last-beat in the same cycle: flush wins. Beat not accepted, no write, abort pulse.
- Watchdog reaching LOCK_MAX and flush in the same cycle: one abort pulse only, ptr unchanged (flush rule).
- Pointer wrap: owner NREQ-1 sets ptr to 0.
- Starvation bound: a requester holding req is granted within NREQ-1 bursts.

Test Plan:
- Single beats: req=3'b111, all last=1, held 3 cycles from reset -> gnt 001, 010, 100 in successive cycles. Writes appear one cycle later in the same order; ptr wraps to 0.
- Atomic burst:
  - Stimulus: req1 issues idx=PC(0), data=48'h0000_0100, last=0, then idx=FL, data=48'h1, last=1. req0 is held high throughout.
  - Required: writes PC then FL on consecutive cycles; ow_busy=1 between; gnt0 only after the burst; ptr=2.
- Watchdog, LOCK_MAX=3: req2 sends a last=0 beat, then drops req -> gnt stays 100 for 3 idle cycles, then ow_lock_abort pulses once. req0 is granted the following cycle; no stray write.
- Flush: flush while req0 is locked and presenting a last=1 beat -> no gnt and no write that cycle, abort pulse, IDLE next cycle. Flush in IDLE with req=0 -> no pulse.
- Reset mid-lock: iw_rst_n low asynchronously between clock edges during LOCK -> all outputs 0 immediately. After release, IDLE with ptr=0 and no abort pulse.
